// File: rtl/rpc_resp_pkg.sv
// rpc_resp_pkg: shared sizes, response codes and FIFO entry types for the RPC response buffer
// Sizes are fixed here so every entry type has a known packed width.
package rpc_resp_pkg;
  localparam int DataWidth = 256;
  localparam int LenWidth  = 6;
  localparam int RDepth    = 128;
  localparam int CmdDepth  = 4;
  localparam int BDepth    = 4;
  localparam int IdWidth   = 6;
  localparam int UserWidth = 1;
  localparam int CredWidth = $clog2(RDepth + 1);
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;
  typedef enum logic {
    IDLE,
    STREAM
  } trk_state_e;
  typedef struct packed {
    logic [UserWidth-1:0] user;
    logic [IdWidth-1:0]   id;
    resp_e                resp;
  } b_entry_t;
  typedef struct packed {
    logic [UserWidth-1:0] user;
    logic [IdWidth-1:0]   id;
    logic [LenWidth-1:0]  len;
  } rcmd_entry_t;
  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 err;
  } rbeat_t;
endpackage

// File: rtl/rpc_resp_beat_tracker.sv
// rpc_resp_beat_tracker: read-command FIFO plus beat counter that marks the last beat of each burst
// Ports: push_i/cmd_i enqueue an accepted read, beat_pop_i one R beat consumed,
//        head_o head command, empty_o/full_o FIFO status, r_last_o head burst is on its last beat.
// r_last_o is decoded from beat_cnt rather than the FSM state: a beat can be consumed in the very
// cycle the first command becomes visible, before the FSM has left IDLE.
module rpc_resp_beat_tracker
  import rpc_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  rcmd_entry_t cmd_i,
  input  logic        beat_pop_i,
  output rcmd_entry_t head_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        r_last_o
);
  localparam int CW = $clog2(CmdDepth + 1);
  logic [CW-1:0] cnt;
  logic [LenWidth-1:0] beat_cnt;
  trk_state_e state;
  logic last_pop;
  rpc_resp_fifo #(.Width($bits(rcmd_entry_t)), .Depth(CmdDepth)) u_cmd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_i),
    .data_i (cmd_i),
    .pop_i  (last_pop),
    .data_o (head_o),
    .cnt_o  (cnt)
  );
  assign empty_o  = cnt == '0;
  assign full_o   = cnt == CW'(CmdDepth);
  assign r_last_o = !empty_o && beat_cnt == head_o.len;
  assign last_pop = beat_pop_i && r_last_o;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      beat_cnt <= last_pop ? '0 : beat_cnt + LenWidth'(beat_pop_i);
      state    <= (state == IDLE) ? (empty_o ? IDLE : STREAM)
                : ((last_pop && cnt == CW'(1) && !push_i) ? IDLE : STREAM);
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk_i)
    if (!rst_i) assert (state == STREAM || beat_cnt == '0)
      else $error("beat tracker idle with a partial burst count");
`endif
endmodule

// File: rtl/rpc_resp_fifo.sv
// rpc_resp_fifo: first-word-fall-through FIFO with occupancy count
// Ports: push_i/data_i write side, pop_i/data_o read side (data_o is the head), cnt_o occupancy.
// Push when full and pop when empty are ignored. Depth must be a power of two (pointers wrap freely).
module rpc_resp_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             data_o,
  output logic [$clog2(Depth+1)-1:0]   cnt_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push_i && (cnt_o != CW'(Depth));
  assign do_pop  = pop_i && (cnt_o != '0);
  assign data_o  = mem[rd_ptr];
  always_ff @(posedge clk_i) if (do_push) mem[wr_ptr] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_o  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      cnt_o  <= cnt_o + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rpc_resp_buffer_mc.sv
// rpc_resp_buffer_mc: RPC DRAM response buffer feeding AXI B and R channels in command order
// Ports: cmd_* presented command (fires on cmd_valid_i & cmd_ready_i), buf_resp_ready_o room for it;
//        b_* AXI B channel; r_* AXI R channel; phy_r_* PHY read beats; r_credits_o free unreserved beats.
// Read credits are reserved at command accept so the data FIFO can never overflow.
// Build option RPC_RESP_BUF_REG_OUT_EN: spill register on the R outputs (2-cycle latency,
// credit returned when the spill register is popped). Undefined: R driven from FIFO heads.
module rpc_resp_buffer_mc
  import rpc_resp_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_is_write_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic [IdWidth-1:0]   cmd_id_i,
  input  logic [UserWidth-1:0] cmd_user_i,
  input  logic                 cmd_valid_i,
  input  logic                 cmd_ready_i,
  output logic                 buf_resp_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [UserWidth-1:0] b_user_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [DataWidth-1:0] r_data_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [UserWidth-1:0] r_user_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  input  logic [DataWidth-1:0] phy_r_data_i,
  input  logic                 phy_r_err_i,
  input  logic                 phy_r_valid_i,
  output logic                 phy_r_ready_o,
  output logic [CredWidth-1:0] r_credits_o
);
  localparam int BCW = $clog2(BDepth + 1);
  logic [BCW-1:0] b_cnt;
  logic [CredWidth-1:0] d_cnt, beats_req;
  logic fire, rd_fire, wr_fire, beat_pop, credit_ret, fifo_valid, c_empty, c_full, trk_last;
  b_entry_t b_in, b_head;
  rbeat_t d_in, d_head;
  rcmd_entry_t c_in, c_head;
  assign beats_req        = CredWidth'(cmd_len_i) + CredWidth'(1);
  assign buf_resp_ready_o = cmd_is_write_i ? (b_cnt != BCW'(BDepth)) : (beats_req <= r_credits_o) && !c_full;
  assign fire             = cmd_valid_i && cmd_ready_i && buf_resp_ready_o;
  assign wr_fire          = fire && cmd_is_write_i;
  assign rd_fire          = fire && !cmd_is_write_i;
  assign b_in             = '{user: cmd_user_i, id: cmd_id_i, resp: RESP_OKAY};
  assign c_in             = '{user: cmd_user_i, id: cmd_id_i, len: cmd_len_i};
  assign d_in             = '{data: phy_r_data_i, err: phy_r_err_i};
  rpc_resp_fifo #(.Width($bits(b_entry_t)), .Depth(BDepth)) u_b (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (wr_fire),
    .data_i (b_in),
    .pop_i  (b_ready_i),
    .data_o (b_head),
    .cnt_o  (b_cnt)
  );
  assign b_valid_o = b_cnt != '0;
  assign b_id_o    = b_head.id;
  assign b_user_o  = b_head.user;
  assign b_resp_o  = b_head.resp;
  rpc_resp_fifo #(.Width($bits(rbeat_t)), .Depth(RDepth)) u_data (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (phy_r_valid_i),
    .data_i (d_in),
    .pop_i  (beat_pop),
    .data_o (d_head),
    .cnt_o  (d_cnt)
  );
  assign phy_r_ready_o = d_cnt != CredWidth'(RDepth);
  rpc_resp_beat_tracker u_trk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (rd_fire),
    .cmd_i      (c_in),
    .beat_pop_i (beat_pop),
    .head_o     (c_head),
    .empty_o    (c_empty),
    .full_o     (c_full),
    .r_last_o   (trk_last)
  );
  assign fifo_valid = d_cnt != '0 && !c_empty;
`ifdef RPC_RESP_BUF_REG_OUT_EN
  logic load;
  assign load       = fifo_valid && (!r_valid_o || r_ready_i);
  assign beat_pop   = load;
  assign credit_ret = r_valid_o && r_ready_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_o <= 1'b0;
      r_last_o  <= 1'b0;
      r_data_o  <= '0;
      r_id_o    <= '0;
      r_user_o  <= '0;
      r_resp_o  <= RESP_OKAY;
    end else if (load) begin
      r_valid_o <= 1'b1;
      r_last_o  <= trk_last;
      r_data_o  <= d_head.data;
      r_id_o    <= c_head.id;
      r_user_o  <= c_head.user;
      r_resp_o  <= d_head.err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_ready_i) r_valid_o <= 1'b0;
  end
`else
  assign r_valid_o  = fifo_valid;
  assign r_last_o   = trk_last;
  assign r_data_o   = d_head.data;
  assign r_id_o     = c_head.id;
  assign r_user_o   = c_head.user;
  assign r_resp_o   = d_head.err ? RESP_SLVERR : RESP_OKAY;
  assign beat_pop   = fifo_valid && r_ready_i;
  assign credit_ret = beat_pop;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_credits_o <= CredWidth'(RDepth);
    else r_credits_o <= r_credits_o - (rd_fire ? beats_req : '0) + CredWidth'(credit_ret);
  end
`ifndef SYNTHESIS
  always @(posedge clk_i)
    if (!rst_i) assert (!(phy_r_valid_i && c_empty && r_credits_o == CredWidth'(RDepth)))
      else $error("phy beat arrived with no read command outstanding");
`endif
endmodule

// File: tb/tb_rpc_resp_buffer_mc.sv
// tb_rpc_resp_buffer_mc: directed self-checking bench for rpc_resp_buffer_mc (default build)
module tb_rpc_resp_buffer_mc;
  import rpc_resp_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i;
  logic cmd_is_write_i, cmd_valid_i, cmd_ready_i;
  logic [LenWidth-1:0] cmd_len_i;
  logic [IdWidth-1:0] cmd_id_i;
  logic [UserWidth-1:0] cmd_user_i;
  logic buf_resp_ready_o;
  logic [IdWidth-1:0] b_id_o, r_id_o;
  logic [UserWidth-1:0] b_user_o, r_user_o;
  logic [1:0] b_resp_o, r_resp_o;
  logic b_valid_o, b_ready_i;
  logic [DataWidth-1:0] r_data_o, phy_r_data_i;
  logic r_last_o, r_valid_o, r_ready_i;
  logic phy_r_err_i, phy_r_valid_i, phy_r_ready_o;
  logic [CredWidth-1:0] r_credits_o;
  int vectors = 0;
  int miscompares = 0;
  logic [DataWidth:0] phy_q[$];
  logic [IdWidth-1:0] eid[$];
  logic elast[$];
  logic [1:0] eresp[$];
  logic [DataWidth-1:0] edata[$];
  rpc_resp_buffer_mc dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_is_write_i(cmd_is_write_i), .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
    .cmd_user_i(cmd_user_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_i(cmd_ready_i),
    .buf_resp_ready_o(buf_resp_ready_o),
    .b_id_o(b_id_o), .b_user_o(b_user_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .r_data_o(r_data_o), .r_id_o(r_id_o), .r_user_o(r_user_o), .r_resp_o(r_resp_o),
    .r_last_o(r_last_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .phy_r_data_i(phy_r_data_i), .phy_r_err_i(phy_r_err_i), .phy_r_valid_i(phy_r_valid_i),
    .phy_r_ready_o(phy_r_ready_o), .r_credits_o(r_credits_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [DataWidth-1:0] mk(input int i);
    return {8{32'(i) ^ 32'h5A5A_0000}};
  endfunction
  task automatic chk(input string tag, input logic [DataWidth-1:0] obs, input logic [DataWidth-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic fire_cmd(input logic w, input logic [LenWidth-1:0] len, input logic [IdWidth-1:0] id,
                          input logic [UserWidth-1:0] user);
    @(posedge clk_i); #1;
    cmd_is_write_i = w; cmd_len_i = len; cmd_id_i = id; cmd_user_i = user;
    cmd_valid_i = 1'b1; cmd_ready_i = 1'b1;
    #1 chk("cmd_ready", buf_resp_ready_o, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_ready_i = 1'b0;
  endtask
  task automatic add(input logic [IdWidth-1:0] id, input logic last, input logic err, input logic [1:0] resp,
                     input logic [DataWidth-1:0] d);
    phy_q.push_back({err, d});
    eid.push_back(id); elast.push_back(last); eresp.push_back(resp); edata.push_back(d);
  endtask
  task automatic stream(input string tag);
    int cyc = 0;
    r_ready_i = 1'b1;
    while (eid.size() > 0 && cyc < 400) begin
      @(posedge clk_i); #1;
      if (phy_q.size() > 0) begin
        phy_r_valid_i = 1'b1;
        {phy_r_err_i, phy_r_data_i} = phy_q.pop_front();
      end else phy_r_valid_i = 1'b0;
      #1;
      if (r_valid_o) begin
        chk({tag, "_id"}, r_id_o, eid.pop_front());
        chk({tag, "_last"}, r_last_o, elast.pop_front());
        chk({tag, "_resp"}, r_resp_o, eresp.pop_front());
        chk({tag, "_data"}, r_data_o, edata.pop_front());
      end
      cyc++;
    end
    vectors++;
    assert (eid.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_timeout: observed %0d beats missing expected 0", tag, eid.size());
    end
    eid.delete(); elast.delete(); eresp.delete(); edata.delete(); phy_q.delete();
    @(posedge clk_i); #1;
    phy_r_valid_i = 1'b0; r_ready_i = 1'b0;
  endtask
  initial begin
    rst_i = 1'b1;
    cmd_is_write_i = 0; cmd_len_i = 0; cmd_id_i = 0; cmd_user_i = 0; cmd_valid_i = 0; cmd_ready_i = 0;
    b_ready_i = 0; r_ready_i = 0; phy_r_data_i = '0; phy_r_err_i = 0; phy_r_valid_i = 0;
    #12;
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_r_last", r_last_o, 0);
    chk("rst_credits", r_credits_o, 128);
    chk("rst_phy_ready", phy_r_ready_o, 1);
    chk("rst_cmd_ready", buf_resp_ready_o, 1);
    @(posedge clk_i); #1 rst_i = 1'b0;
    fire_cmd(1'b1, 6'd0, 6'h15, 1'b1);
    #1;
    chk("b_valid", b_valid_o, 1);
    chk("b_id", b_id_o, 6'h15);
    chk("b_user", b_user_o, 1);
    chk("b_resp", b_resp_o, 2'b00);
    repeat (5) @(posedge clk_i);
    #1;
    chk("b_stall_valid", b_valid_o, 1);
    chk("b_stall_id", b_id_o, 6'h15);
    b_ready_i = 1'b1;
    @(posedge clk_i); #1 b_ready_i = 1'b0;
    #1 chk("b_popped", b_valid_o, 0);
    fire_cmd(1'b0, 6'd63, 6'h01, 1'b0);
    #1 chk("cred_64", r_credits_o, 64);
    fire_cmd(1'b0, 6'd63, 6'h02, 1'b0);
    #1 chk("cred_0", r_credits_o, 0);
    cmd_is_write_i = 0; cmd_len_i = 0; cmd_id_i = 6'h03; cmd_valid_i = 1'b1; cmd_ready_i = 1'b0;
    #1 chk("full_blocks", buf_resp_ready_o, 0);
    phy_r_valid_i = 1'b1; phy_r_err_i = 1'b0; phy_r_data_i = mk(0);
    @(posedge clk_i); #1 phy_r_valid_i = 1'b0;
    #1;
    chk("first_valid", r_valid_o, 1);
    chk("first_id", r_id_o, 6'h01);
    chk("first_last", r_last_o, 0);
    chk("first_data", r_data_o, mk(0));
    chk("still_blocked", buf_resp_ready_o, 0);
    r_ready_i = 1'b1;
    @(posedge clk_i); #1 r_ready_i = 1'b0;
    #1;
    chk("cred_1", r_credits_o, 1);
    chk("unblocked", buf_resp_ready_o, 1);
    cmd_valid_i = 1'b0;
    for (int i = 1; i < 128; i++) add(i < 64 ? 6'h01 : 6'h02, i == 63 || i == 127, 1'b0, 2'b00, mk(i));
    stream("rd128");
    #1 chk("cred_back_128", r_credits_o, 128);
    fire_cmd(1'b0, 6'd3, 6'h07, 1'b0);
    #1 chk("cred_124", r_credits_o, 124);
    for (int i = 0; i < 4; i++) add(6'h07, i == 3, 1'b0, 2'b00, mk(200 + i));
    stream("rd4");
    #1 chk("cred_rd4", r_credits_o, 128);
    fire_cmd(1'b0, 6'd0, 6'h01, 1'b0);
    fire_cmd(1'b0, 6'd1, 6'h02, 1'b0);
    #1 chk("cred_125", r_credits_o, 125);
    add(6'h01, 1'b1, 1'b0, 2'b00, mk(300));
    add(6'h02, 1'b0, 1'b0, 2'b00, mk(301));
    add(6'h02, 1'b1, 1'b0, 2'b00, mk(302));
    stream("ilv");
    fire_cmd(1'b0, 6'd3, 6'h09, 1'b1);
    for (int i = 0; i < 4; i++) add(6'h09, i == 3, i == 1, i == 1 ? 2'b10 : 2'b00, mk(400 + i));
    stream("err");
    #1 chk("cred_err", r_credits_o, 128);
    fire_cmd(1'b0, 6'd3, 6'h0A, 1'b0);
    add(6'h0A, 1'b0, 1'b0, 2'b00, mk(500));
    phy_q.push_back({1'b0, mk(501)});
    stream("pre_rst");
    #1;
    chk("pre_rst_valid", r_valid_o, 1);
    chk("pre_rst_cred", r_credits_o, 125);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", r_valid_o, 0);
    chk("mid_rst_cred", r_credits_o, 128);
    chk("mid_rst_last", r_last_o, 0);
    chk("mid_rst_phy_ready", phy_r_ready_o, 1);
    @(posedge clk_i); #1 rst_i = 1'b0;
    fire_cmd(1'b0, 6'd1, 6'h0B, 1'b0);
    add(6'h0B, 1'b0, 1'b0, 2'b00, mk(600));
    add(6'h0B, 1'b1, 1'b0, 2'b00, mk(601));
    stream("post_rst");
    #1 chk("cred_final", r_credits_o, 128);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
